alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/cpu_ctrl_pkg.sv | 54 +++++
 rtl/alu_sequencer_reg_select.sv | 22 ++
 rtl/alu_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ALU fetch/execute sequencer: states, opcodes, IR layout.
// The ALU_SEQ_MULDIV_EN macro adds the T6 state and makes mul/div legal opcodes.
package cpu_ctrl_pkg;

  localparam int OPC_W  = 5;
  localparam int FLD_W  = 4;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [OPC_W-1:0] OP_ADD = 5'd3;
  localparam logic [OPC_W-1:0] OP_SUB = 5'd4;
  localparam logic [OPC_W-1:0] OP_AND = 5'd5;
  localparam logic [OPC_W-1:0] OP_OR  = 5'd6;
  localparam logic [OPC_W-1:0] OP_SHR = 5'd7;
  localparam logic [OPC_W-1:0] OP_SHL = 5'd8;
  localparam logic [OPC_W-1:0] OP_ROR = 5'd9;
  localparam logic [OPC_W-1:0] OP_ROL = 5'd10;
  localparam logic [OPC_W-1:0] OP_MUL = 5'd15;
  localparam logic [OPC_W-1:0] OP_DIV = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5
`ifdef ALU_SEQ_MULDIV_EN
    , S_T6
`endif
  } state_e;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in;
    logic zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in;
    logic busy, done, illegal;
  } ctrl_t;

  function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_ROL, OP_ROR: return 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
      OP_MUL, OP_DIV: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_reg_select.sv
// One-hot general register select decoder with an out-of-range flag.
module reg_select_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [FLD_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] sel,
  output logic                oor
);

  // The range flag ignores the enable so the sequencer can vet fields ahead of use.
  always_comb begin
    sel = '0;
    oor = (32'(idx) >= NUM_REGS);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && !oor && (32'(idx) == i)) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Moore control sequencer stepping one fetch/execute cycle through the CPU datapath.
// Define ALU_SEQ_MULDIV_EN to enable the mul/div path (state T6, HI/LO loads).
module alu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [WORD_W-1:0]   ir,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                ZLowIn,
  output logic                ZHighIn,
  output logic                ZLowOut,
  output logic                ZHighout,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [4:0]          alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   op_q, op_d;
  logic [FLD_W-1:0]   ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [OPC_W-1:0]   alu_op_q, alu_op_d;
  logic [NUM_REGS-1:0] reg_in_q, reg_in_d, reg_out_q, reg_out_d;
  logic [FLD_W-1:0]   out_idx;
  logic               in_en, out_en, in_oor, out_oor, rc_oor, bad;
  logic               unused_ir;

  assign unused_ir = ^ir;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2: begin
        state_d = S_T3;
        op_d    = ir[OPC_MSB:OPC_LSB];
        ra_d    = ir[RA_MSB:RA_LSB];
        rb_d    = ir[RB_MSB:RB_LSB];
        rc_d    = ir[RC_MSB:RC_LSB];
      end
      S_T3:   state_d = ctrl_q.illegal ? S_IDLE : S_T4;
      S_T4:   state_d = S_T5;
`ifdef ALU_SEQ_MULDIV_EN
      S_T5:   state_d = is_muldiv(op_q) ? S_T6 : S_IDLE;
      S_T6:   state_d = S_IDLE;
`else
      S_T5:   state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded one cycle early from the next state so the flops hold the Moore value.
  assign out_idx = (state_d == S_T4) ? rc_d : rb_d;
  assign rc_oor  = (32'(rc_d) >= NUM_REGS);
  assign bad     = !op_legal(op_d) || in_oor || out_oor || rc_oor;

  always_comb begin
    ctrl_d      = '0;
    in_en       = 1'b0;
    out_en      = 1'b0;
    alu_op_d    = '0;
    ctrl_d.busy = (state_d != S_IDLE);
    unique case (state_d)
      S_T0: begin
        ctrl_d.pc_out  = 1'b1;
        ctrl_d.mar_in  = 1'b1;
        ctrl_d.inc_pc  = 1'b1;
        ctrl_d.zlow_in = 1'b1;
      end
      S_T1: begin
        ctrl_d.read   = 1'b1;
        ctrl_d.mdr_in = 1'b1;
      end
      S_T2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      S_T3: begin
        alu_op_d = op_d;
        if (bad) begin
          ctrl_d.illegal = 1'b1;
        end else begin
          out_en      = 1'b1;
          ctrl_d.y_in = 1'b1;
        end
      end
      S_T4: begin
        alu_op_d       = op_d;
        out_en         = 1'b1;
        ctrl_d.zlow_in = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
        ctrl_d.zhigh_in = is_muldiv(op_d);
`endif
      end
      S_T5: begin
        alu_op_d        = op_d;
        ctrl_d.zlow_out = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
        if (is_muldiv(op_d)) begin
          ctrl_d.lo_in = 1'b1;
        end else begin
          in_en       = 1'b1;
          ctrl_d.done = 1'b1;
        end
      end
      S_T6: begin
        alu_op_d         = op_d;
        ctrl_d.zhigh_out = 1'b1;
        ctrl_d.hi_in     = 1'b1;
        ctrl_d.done      = 1'b1;
`else
        in_en       = 1'b1;
        ctrl_d.done = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_in_dec (
    .idx(ra_d), .en(in_en), .sel(reg_in_d), .oor(in_oor)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_out_dec (
    .idx(out_idx), .en(out_en), .sel(reg_out_d), .oor(out_oor)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      ctrl_q    <= '0;
      alu_op_q  <= '0;
      reg_in_q  <= '0;
      reg_out_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      ctrl_q    <= ctrl_d;
      alu_op_q  <= alu_op_d;
      reg_in_q  <= reg_in_d;
      reg_out_q <= reg_out_d;
    end
  end

  assign PCout    = ctrl_q.pc_out;
  assign MARin    = ctrl_q.mar_in;
  assign IncPC    = ctrl_q.inc_pc;
  assign Read     = ctrl_q.read;
  assign MDRin    = ctrl_q.mdr_in;
  assign MDRout   = ctrl_q.mdr_out;
  assign IRin     = ctrl_q.ir_in;
  assign Yin      = ctrl_q.y_in;
  assign ZLowIn   = ctrl_q.zlow_in;
  assign ZHighIn  = ctrl_q.zhigh_in;
  assign ZLowOut  = ctrl_q.zlow_out;
  assign ZHighout = ctrl_q.zhigh_out;
  assign LOin     = ctrl_q.lo_in;
  assign HIin     = ctrl_q.hi_in;
  assign busy     = ctrl_q.busy;
  assign done     = ctrl_q.done;
  assign illegal  = ctrl_q.illegal;
  assign alu_op   = alu_op_q;
  assign reg_in   = reg_in_q;
  assign reg_out  = reg_out_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a per-cycle expected-output list built from the sequencing rules.
module tb_alu_sequencer;
  import cpu_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        clear, start, mem_ready;
  logic [31:0] ir;
  logic        PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin;
  logic        ZLowIn, ZHighIn, ZLowOut, ZHighout, LOin, HIin;
  logic [15:0] reg_in, reg_out;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;

  always #5 clock = ~clock;

  alu_sequencer #(.WORD_W(32), .NUM_REGS(16)) dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .ZLowOut(ZLowOut), .ZHighout(ZHighout), .LOin(LOin), .HIin(HIin),
    .reg_in(reg_in), .reg_out(reg_out), .alu_op(alu_op),
    .busy(busy), .done(done), .illegal(illegal)
  );

  typedef struct packed {
    logic [13:0] strb;
    logic        busy, done, illegal;
    logic [4:0]  op;
    logic [15:0] rin, rout;
  } obs_t;

  localparam int B_PC = 13, B_MAR = 12, B_INC = 11, B_RD = 10, B_MDRI = 9, B_MDRO = 8;
  localparam int B_IR = 7, B_Y = 6, B_ZLI = 5, B_ZHI = 4, B_ZLO = 3, B_ZHO = 2, B_LO = 1, B_HI = 0;

  obs_t obs;
  assign obs = {PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn, ZHighIn,
                ZLowOut, ZHighout, LOin, HIin, busy, done, illegal, alu_op, reg_in, reg_out};

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  task automatic check(input string tag, input obs_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc,
                                        input logic [14:0] low);
    return {op, ra, rb, rc, low};
  endfunction

  // Expected output list: T0, T1 x (waits+1), T2, T3, then T4/T5[/T6] for legal opcodes.
  task automatic build(input logic [31:0] instr, input int waits);
    obs_t e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    bit md, legal;
    op = instr[31:27];
    ra = instr[26:23];
    rb = instr[22:19];
    rc = instr[18:15];
    md = (op == OP_MUL) || (op == OP_DIV);
    legal = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_ROL, OP_ROR};
`ifdef ALU_SEQ_MULDIV_EN
    if (md) legal = 1'b1;
`endif
    exp_q.delete();
    e = '0; e.busy = 1'b1;
    e.strb[B_PC] = 1'b1; e.strb[B_MAR] = 1'b1; e.strb[B_INC] = 1'b1; e.strb[B_ZLI] = 1'b1;
    exp_q.push_back(e);
    e = '0; e.busy = 1'b1; e.strb[B_RD] = 1'b1; e.strb[B_MDRI] = 1'b1;
    repeat (waits + 1) exp_q.push_back(e);
    e = '0; e.busy = 1'b1; e.strb[B_MDRO] = 1'b1; e.strb[B_IR] = 1'b1;
    exp_q.push_back(e);
    e = '0; e.busy = 1'b1; e.op = op;
    if (legal) begin
      e.rout = 16'h1 << rb;
      e.strb[B_Y] = 1'b1;
    end else begin
      e.illegal = 1'b1;
    end
    exp_q.push_back(e);
    if (legal) begin
      e = '0; e.busy = 1'b1; e.op = op; e.rout = 16'h1 << rc;
      e.strb[B_ZLI] = 1'b1; e.strb[B_ZHI] = md;
      exp_q.push_back(e);
      e = '0; e.busy = 1'b1; e.op = op; e.strb[B_ZLO] = 1'b1;
      if (md) e.strb[B_LO] = 1'b1;
      else begin e.rin = 16'h1 << ra; e.done = 1'b1; end
      exp_q.push_back(e);
      if (md) begin
        e = '0; e.busy = 1'b1; e.op = op; e.done = 1'b1;
        e.strb[B_ZHO] = 1'b1; e.strb[B_HI] = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  // Launches one sequence from IDLE and checks every cycle; abort_at>=0 pulls clear low in that cycle.
  task automatic run_seq(input logic [31:0] instr, input int waits, input bit hold,
                         input int abort_at, input string tag);
    build(instr, waits);
    ir = instr;
    start = 1'b1;
    mem_ready = 1'b0;
    foreach (exp_q[i]) begin
      @(posedge clock); #1;
      if (!hold) start = 1'b0;
      check($sformatf("%s_c%0d", tag, i), exp_q[i]);
      mem_ready = (i >= waits + 1);
      if (i == abort_at) begin
        #2 clear = 1'b0;
        #1 check($sformatf("%s_clear", tag), '0);
        #1 clear = 1'b1;
        break;
      end
    end
    @(posedge clock); #1;
    mem_ready = 1'b0;
    check($sformatf("%s_idle", tag), '0);
  endtask

  initial begin
    clear = 1'b0;
    start = 1'b0;
    mem_ready = 1'b0;
    ir = '0;
    #2 check("reset_async", '0);
    start = 1'b1;
    repeat (2) @(posedge clock);
    #1 check("reset_hold", '0);
    start = 1'b0;
    clear = 1'b1;
    @(posedge clock); #1;
    check("idle_no_start", '0);

    run_seq(32'h322B8000, 0, 1'b0, -1, "or_basic");
    run_seq(32'h322B8000, 3, 1'b0, -1, "or_wait3");
    run_seq(mk_ir(OP_MUL, 4'd2, 4'd3, 4'd6, 15'h0), 1, 1'b0, -1, "mul");
    run_seq(mk_ir(5'b11111, 4'd1, 4'd2, 4'd3, 15'h0), 0, 1'b0, -1, "op_bad");
    run_seq(32'h322B8000, 0, 1'b0, 4, "clear_t4");
    run_seq(mk_ir(OP_SUB, 4'd9, 4'd0, 4'd15, 15'h1234), 2, 1'b0, -1, "after_clear");
    run_seq(mk_ir(OP_ADD, 4'd1, 4'd14, 4'd8, 15'h0), 0, 1'b1, -1, "hold_a");
    run_seq(mk_ir(OP_ROL, 4'd15, 4'd7, 4'd0, 15'h0), 1, 1'b1, -1, "hold_b");
    start = 1'b0;
    @(posedge clock); #1;
    check("hold_stop", '0);

    for (int n = 0; n < 10; n++) begin
      logic [4:0] op;
      logic [4:0] legal_ops [10];
      legal_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_MUL, OP_DIV};
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
      else op = legal_ops[$urandom_range(0, 9)];
      run_seq(mk_ir(op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)),
              $urandom_range(0, 3), 1'b0, -1, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
